// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
// ---------------------------------------------------------------------------
// Single-clock FIFO for the DMA read datapath. It has an exact occupancy
// count, programmable almost-full/almost-empty levels and one-cycle
// overflow/underflow pulses. The read side runs either in standard mode
// (dout updates one edge after an accepted read) or in first-word
// fall-through mode (dout always shows the head word while not empty).
//
// Ports
//   i_clk        in   1             rising-edge clock
//   i_rst_n      in   1             asynchronous active-low reset
//   din          in   BITS_WIDTH    write data
//   wr_en        in   1             write request
//   rd_en        in   1             read request (FWFT: pop/acknowledge of dout)
//   dout         out  BITS_WIDTH    registered read data
//   full         out  1             count == DEPTH
//   empty        out  1             count == 0
//   almost_full  out  1             count >= AF_THRESH
//   almost_empty out  1             count <= AE_THRESH
//   count        out  BITS_DEPTH+1  words held, 0..DEPTH
//   overflow     out  1             pulse: a write was rejected last edge
//   underflow    out  1             pulse: a read was rejected last edge
// ---------------------------------------------------------------------------
module sync_fifo_flags #(
    parameter int BITS_DEPTH = 8,
    parameter int BITS_WIDTH = 32,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 2**BITS_DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [BITS_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [BITS_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [BITS_DEPTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2**BITS_DEPTH;

    localparam logic [BITS_DEPTH:0] DEPTH_LVL = (BITS_DEPTH+1)'(DEPTH);
    localparam logic [BITS_DEPTH:0] AF_LVL    = (BITS_DEPTH+1)'(AF_THRESH);
    localparam logic [BITS_DEPTH:0] AE_LVL    = (BITS_DEPTH+1)'(AE_THRESH);
    localparam logic [BITS_DEPTH:0] PTR_ONE   = (BITS_DEPTH+1)'(1);

    logic [BITS_WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra bit so that full (diff == DEPTH) and empty
    // (diff == 0) are distinguishable; their difference modulo 2*DEPTH is
    // the exact occupancy at every point, including across wraps.
    logic [BITS_DEPTH:0]   wr_ptr_reg;
    logic [BITS_DEPTH:0]   rd_ptr_reg;
    logic [BITS_WIDTH-1:0] dout_reg;
    logic [BITS_WIDTH-1:0] dout_next;
    logic                  overflow_reg;
    logic                  underflow_reg;

    logic                  wr_acc;
    logic                  rd_acc;
    logic [BITS_DEPTH-1:0] wr_addr;
    logic [BITS_DEPTH-1:0] rd_addr;

    // Flags depend only on registered pointer state, never on the requests.
    assign count        = wr_ptr_reg - rd_ptr_reg;
    assign full         = (count == DEPTH_LVL);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign wr_acc  = wr_en && !full;
    assign rd_acc  = rd_en && !empty;
    assign wr_addr = wr_ptr_reg[BITS_DEPTH-1:0];
    assign rd_addr = rd_ptr_reg[BITS_DEPTH-1:0];

    assign dout      = dout_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

    generate
        if (FWFT != 0) begin : g_fwft
            logic [BITS_DEPTH-1:0] rd_addr_nxt;
            assign rd_addr_nxt = rd_addr + BITS_DEPTH'(1);

            // dout is kept equal to the word the head pointer will point at
            // after this edge. With two or more words stored the successor is
            // already in memory; with exactly one, the successor can only be
            // the word being written in this same cycle.
            always_comb begin
                dout_next = dout_reg;
                if (rd_acc) begin
                    if (count > PTR_ONE) begin
                        dout_next = mem[rd_addr_nxt];
                    end else if (wr_acc) begin
                        dout_next = din;
                    end
                end else if (empty && wr_acc) begin
                    dout_next = din;
                end
            end
        end else begin : g_std
            always_comb begin
                dout_next = dout_reg;
                if (rd_acc) begin
                    dout_next = mem[rd_addr];
                end
            end
        end
    endgenerate

    // Storage is not reset; only the pointers decide what is valid.
    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            dout_reg      <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            dout_reg      <= dout_next;
            // A request is rejected exactly when its own guard flag is set,
            // regardless of what the other port does in the same cycle.
            overflow_reg  <= wr_en && full;
            underflow_reg <= rd_en && empty;
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags
// Bench for sync_fifo_flags with DEPTH=8, WIDTH=8, AF=6, AE=1. One instance
// runs in standard mode, a second in FWFT mode. A vector table covers
// fill/drain and simultaneous access, a reference queue covers random
// traffic across pointer wraps, and short hand-written sequences cover
// reset and FWFT corner cases.
module tb_sync_fifo_flags;

    typedef struct packed {
        logic [3:0] cnt;
        logic [7:0] dout;
        logic [5:0] flg;   // {full, empty, almost_full, almost_empty, overflow, underflow}
    } obs_t;

    typedef struct {
        bit         wr;
        bit         rd;
        logic [7:0] din;
        int         cnt;
        logic [7:0] dout;
        bit         ov;
        bit         un;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] s_din = '0;
    logic       s_wr = 1'b0, s_rd = 1'b0;
    logic [7:0] s_dout;
    logic [3:0] s_count;
    logic       s_full, s_empty, s_af, s_ae, s_ov, s_un;

    logic [7:0] f_din = '0;
    logic       f_wr = 1'b0, f_rd = 1'b0;
    logic [7:0] f_dout;
    logic [3:0] f_count;
    logic       f_full, f_empty, f_af, f_ae, f_ov, f_un;

    obs_t obs_s, obs_f;
    assign obs_s = {s_count, s_dout, s_full, s_empty, s_af, s_ae, s_ov, s_un};
    assign obs_f = {f_count, f_dout, f_full, f_empty, f_af, f_ae, f_ov, f_un};

    int vectors = 0;
    int misc    = 0;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    logic [7:0] cur_dout;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .BITS_DEPTH(3), .BITS_WIDTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)
    ) u_std (
        .i_clk(clk), .i_rst_n(rst_n), .din(s_din), .wr_en(s_wr), .rd_en(s_rd),
        .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ov), .underflow(s_un)
    );

    sync_fifo_flags #(
        .BITS_DEPTH(3), .BITS_WIDTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)
    ) u_fwft (
        .i_clk(clk), .i_rst_n(rst_n), .din(f_din), .wr_en(f_wr), .rd_en(f_rd),
        .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ov), .underflow(f_un)
    );

    function automatic obs_t mk_obs(int c, logic [7:0] d, bit ov, bit un);
        obs_t o;
        o.cnt  = 4'(c);
        o.dout = d;
        o.flg  = {c == 8, c == 0, c >= 6, c <= 1, ov, un};
        return o;
    endfunction

    function automatic void add(bit w, bit r, logic [7:0] d, int c, logic [7:0] o, bit ov, bit un);
        vec_t v;
        v.wr = w; v.rd = r; v.din = d; v.cnt = c; v.dout = o; v.ov = ov; v.un = un;
        vecs.push_back(v);
    endfunction

    task automatic compare(string nm, obs_t act, obs_t exp, bit chk_d);
        vectors++;
        if (act.cnt !== exp.cnt || act.flg !== exp.flg || (chk_d && act.dout !== exp.dout)) begin
            misc++;
            $display("FAIL %s: got count=%0d dout=%02h flags=%06b, want count=%0d dout=%02h flags=%06b",
                     nm, act.cnt, act.dout, act.flg, exp.cnt, exp.dout, exp.flg);
        end else begin
            $display("ok   %s: count=%0d dout=%02h flags=%06b", nm, act.cnt, act.dout, act.flg);
        end
    endtask

    task automatic step_s(bit w, bit r, logic [7:0] d);
        s_wr = w; s_rd = r; s_din = d;
        @(posedge clk);
        #1;
        s_wr = 1'b0; s_rd = 1'b0;
    endtask

    task automatic step_f(bit w, bit r, logic [7:0] d);
        f_wr = w; f_rd = r; f_din = d;
        @(posedge clk);
        #1;
        f_wr = 1'b0; f_rd = 1'b0;
    endtask

    initial begin
        // ---------------- vector table (standard mode) ----------------
        for (int i = 0; i < 8; i++) add(1, 0, 8'h10 + 8'(i), i + 1, 8'h00, 0, 0);
        add(1, 0, 8'hFF, 8, 8'h00, 1, 0);                       // overflow
        add(0, 0, 8'h00, 8, 8'h00, 0, 0);                       // pulse gone
        for (int j = 0; j < 8; j++) add(0, 1, 8'h00, 7 - j, 8'h10 + 8'(j), 0, 0);
        add(0, 1, 8'h00, 0, 8'h17, 0, 1);                       // underflow, dout holds
        add(0, 0, 8'h00, 0, 8'h17, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 0, 8'h20 + 8'(i), i + 1, 8'h17, 0, 0);
        add(1, 1, 8'hEE, 7, 8'h20, 1, 0);                       // full: read only
        add(0, 0, 8'h00, 7, 8'h20, 0, 0);
        for (int j = 0; j < 7; j++) add(0, 1, 8'h00, 6 - j, 8'h21 + 8'(j), 0, 0);
        add(1, 1, 8'h40, 1, 8'h27, 0, 1);                       // empty: write only
        add(0, 0, 8'h00, 1, 8'h27, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 8'h41 + 8'(i), i + 2, 8'h27, 0, 0);
        add(1, 1, 8'h44, 4, 8'h40, 0, 0);                       // count 4: both
        for (int j = 0; j < 4; j++) add(0, 1, 8'h00, 3 - j, 8'h41 + 8'(j), 0, 0);

        // ---------------- reset, asserted mid-cycle ----------------
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        step_s(1, 0, 8'h10);
        step_s(1, 0, 8'h11);
        step_s(0, 1, 8'h00);
        compare("pre_reset", obs_s, mk_obs(1, 8'h10, 0, 0), 1);
        #2 rst_n = 1'b0;
        #1;
        compare("async_reset_std", obs_s, mk_obs(0, 8'h00, 0, 0), 1);
        compare("async_reset_fwft", obs_f, mk_obs(0, 8'h00, 0, 0), 1);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- apply table ----------------
        foreach (vecs[i]) begin
            step_s(vecs[i].wr, vecs[i].rd, vecs[i].din);
            compare($sformatf("vec%0d", i), obs_s,
                    mk_obs(vecs[i].cnt, vecs[i].dout, vecs[i].ov, vecs[i].un), 1);
        end
        cur_dout = vecs[vecs.size()-1].dout;

        // ---------------- random traffic vs reference queue ----------------
        for (int i = 0; i < 100; i++) begin
            bit         w, r;
            logic [7:0] d;
            w = ($urandom_range(0, 99) < ((i < 50) ? 65 : 40)) && (sb.size() < 8);
            r = ($urandom_range(0, 99) < ((i < 50) ? 40 : 65)) && (sb.size() > 0);
            d = 8'($urandom);
            if (r) cur_dout = sb.pop_front();
            if (w) sb.push_back(d);
            step_s(w, r, d);
            compare($sformatf("rnd%0d", i), obs_s, mk_obs(sb.size(), cur_dout, 0, 0), 1);
        end
        for (int k = 0; k < 8 && sb.size() > 0; k++) begin
            cur_dout = sb.pop_front();
            step_s(0, 1, 8'h00);
            compare($sformatf("drain%0d", k), obs_s, mk_obs(sb.size(), cur_dout, 0, 0), 1);
        end

        // ---------------- reset mid-stream ----------------
        for (int k = 0; k < 5; k++) step_s(1, 0, 8'h50 + 8'(k));
        compare("pre_reset5", obs_s, mk_obs(5, cur_dout, 0, 0), 1);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        compare("mid_reset", obs_s, mk_obs(0, 8'h00, 0, 0), 1);
        step_s(1, 0, 8'h33);
        compare("post_rst_wr", obs_s, mk_obs(1, 8'h00, 0, 0), 1);
        step_s(0, 1, 8'h00);
        compare("post_rst_rd", obs_s, mk_obs(0, 8'h33, 0, 0), 1);
        step_s(0, 1, 8'h00);
        compare("post_rst_un", obs_s, mk_obs(0, 8'h33, 0, 1), 1);

        // ---------------- FWFT sequences ----------------
        compare("fwft_idle", obs_f, mk_obs(0, 8'h00, 0, 0), 1);
        step_f(1, 0, 8'hA5);
        compare("fwft_first", obs_f, mk_obs(1, 8'hA5, 0, 0), 1);
        step_f(0, 0, 8'h00);
        compare("fwft_hold", obs_f, mk_obs(1, 8'hA5, 0, 0), 1);
        step_f(1, 1, 8'h5A);
        compare("fwft_rdwr1", obs_f, mk_obs(1, 8'h5A, 0, 0), 1);
        step_f(1, 0, 8'h11);
        compare("fwft_wr2", obs_f, mk_obs(2, 8'h5A, 0, 0), 1);
        step_f(0, 1, 8'h00);
        compare("fwft_rd_a", obs_f, mk_obs(1, 8'h11, 0, 0), 1);
        step_f(0, 1, 8'h00);
        compare("fwft_rd_b", obs_f, mk_obs(0, 8'h00, 0, 0), 0);
        step_f(0, 1, 8'h00);
        compare("fwft_un", obs_f, mk_obs(0, 8'h00, 0, 1), 0);
        for (int k = 0; k < 3; k++) begin
            step_f(1, 0, 8'h61 + 8'(k));
            compare($sformatf("fwft_fill%0d", k), obs_f, mk_obs(k + 1, 8'h61, 0, 0), 1);
        end
        for (int k = 0; k < 2; k++) begin
            step_f(0, 1, 8'h00);
            compare($sformatf("fwft_pop%0d", k), obs_f, mk_obs(2 - k, 8'h62 + 8'(k), 0, 0), 1);
        end
        step_f(0, 1, 8'h00);
        compare("fwft_pop_last", obs_f, mk_obs(0, 8'h00, 0, 0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Next-generation single-clock FIFO for the DMA read datapath.
- Parametrised width and depth.
- Selectable read mode: standard 1-cycle read latency, or first-word fall-through (FWFT).
- Provides an exact occupancy count, programmable almost-full/almost-empty thresholds and overflow/underflow error pulses.
- Sits between the DMA read-response path and downstream consumers that need early back-pressure.

Parameters:
- BITS_DEPTH, 8: log2 of storage depth; capacity DEPTH = 2**BITS_DEPTH words (exactly, both modes).
- BITS_WIDTH, 32: data word width.
- FWFT, 0: 0 = standard mode; 1 = first-word fall-through.
- AF_THRESH, 2**BITS_DEPTH-2: almost_full asserted when count >= AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserted when count <= AE_THRESH. Legal range 0..DEPTH-1.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- din  in  BITS_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request; in FWFT mode this is the pop/acknowledge of dout.
- dout  out  BITS_WIDTH  registered read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0 (FWFT: dout not valid).
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  BITS_DEPTH+1  words held, range 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - Pointers, count and dout clear to 0.
  - empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
  - Memory contents are not reset.
  - Deassertion is taken synchronously on the next i_clk edge.
  - Reset mid-operation discards all stored data; the first post-reset write is the next word read.
- Accept rules, evaluated from flag values before the edge:
  - Write accepted iff wr_en && !full.
  - Read accepted iff rd_en && !empty.
  - When full, a simultaneous rd_en+wr_en performs the read only; the write is rejected and overflow pulses.
  - When empty, a simultaneous rd_en+wr_en performs the write only; underflow pulses.
- Count update per edge:
  - +1 on write-only accept.
  - -1 on read-only accept.
  - Unchanged when both or neither are accepted.
  - Never exceeds DEPTH and never goes below 0.
- Flags:
  - All flags are functions of registered count (pointer state) and update on the same edge as count.
  - No combinational path from wr_en/rd_en to any flag or dout.
- Pointers:
  - BITS_DEPTH+1 bits, wrapping modulo 2*DEPTH.
  - Address taken from the low BITS_DEPTH bits.
  - Wrap must be seamless across arbitrary numbers of cycles.
- Standard mode (FWFT=0):
  - On an accepted read at edge N, dout takes the head word after edge N.
  - dout holds its last value otherwise, including on rejected reads.
- FWFT mode (FWFT=1):
  - Whenever empty=0, dout equals the head word.
  - A write into an empty FIFO at edge N gives empty=0 and dout=that word after edge N.
  - An accepted read at edge N advances dout to the next word after edge N, or sets empty=1 if count was 1.
  - Correct when the next word is being written in the same cycle (count==1 with rd+wr): dout = new din after the edge.
  - dout value when empty=1 is don't-care but must not be X after reset.
- overflow/underflow:
  - High for exactly the one cycle following the edge where the rejected request was sampled.
  - Not sticky.
- Ordering: strictly first-in first-out; no data loss or duplication for any accepted sequence.

Test Plan (BITS_DEPTH=3, BITS_WIDTH=8, AF_THRESH=6, AE_THRESH=1 unless noted):
- Reset check: assert i_rst_n=0 asynchronously mid-cycle -> empty=1, count=0, dout=0, almost_empty=1 immediately, before any clock edge.
- Fill/drain, FWFT=0: write 0x10..0x17 -> count 1..8, almost_full at count=6, full at 8. A 9th write (0xFF) -> overflow pulse for 1 cycle, count stays 8. Read 8 -> dout 0x10..0x17 each one edge after its rd_en; a 9th read -> underflow pulse, dout stays 0x17.
- Simultaneous access: at count=8 assert rd+wr -> count=7, din dropped, overflow=1. At count=0 assert rd+wr -> count=1, underflow=1. At count=4 assert rd+wr -> count stays 4 and ordering is preserved.
- Wrap-around: 100 cycles of random rd/wr, keeping count within 0..8, checked against a reference queue -> no mismatch across pointer wraps; count always equals queue length.
- FWFT=1: write 0xA5 into an empty FIFO -> next cycle empty=0, dout=0xA5 with no rd_en. At count=1 assert rd+wr(0x5A) -> dout=0x5A, count=1, empty=0.
- Reset mid-stream: with count=5, pulse i_rst_n low, then write 0x33 and read -> dout=0x33; no pre-reset data appears.
